// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared types and constants for the 8-way round-robin arbiter
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Highest requester index; the pointer wraps to 0 after it.
  localparam logic [IDX_W-1:0] c_PTR_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == c_PTR_LAST) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_encoder_8_if.sv
// ============================================================================
// rr_grant_encoder_8_if : request/grant bundle between requesters and arbiter
// Revision              : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_grant_encoder_8_if;
  import rr_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// rr_pick8 : combinational round-robin picker, first set req bit from ptr up
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick8
  import rr_arb_pkg::*;
(
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0] i_ptr,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Doubling the vector turns the rotate into a plain shift.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  assign o_found = |i_req;
  assign o_idx   = w_off + i_ptr;

endmodule

`default_nettype wire

// File: rtl/rr_grant_encoder_8.sv
// ============================================================================
// rr_grant_encoder_8 : round-robin arbiter with hold timeout, one-hot and
//                      encoded grant outputs
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_grant_encoder_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rr_grant_encoder_8_if.slave bus
);

  localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

  state_t           r_state,    w_state_nxt;
  logic [IDX_W-1:0] r_ptr,      w_ptr_nxt;
  logic [7:0]       r_hold_cnt, w_hold_nxt;
  logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx,  w_idx_nxt;
  logic             r_valid,    w_valid_nxt;
  logic             r_timeout,  w_timeout_nxt;

  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;

  rr_pick8 u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_gnt_idx;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = '0;
        if (bus.en && w_found) begin
          w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd1;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        if (!bus.en || bus.done || !bus.req[r_gnt_idx] || (r_hold_cnt == c_MAX_HOLD)) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_hold_nxt  = '0;
          // An abort keeps the pointer; every other release rotates past the owner.
          if (bus.en) begin
            w_ptr_nxt     = next_ptr(r_gnt_idx);
            w_timeout_nxt = !bus.done && bus.req[r_gnt_idx];
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_valid;
  assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_encoder_8.sv
// ============================================================================
// tb_rr_grant_encoder_8 : scenario bench for the round-robin grant encoder
// Revision              : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_encoder_8;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
  } vec_t;

  typedef logic [12:0] exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  vec_t plan[$];
  exp_t sb[$];

  rr_grant_encoder_8_if bus ();

  rr_grant_encoder_8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One planned cycle: inputs before an edge, outputs required after it.
  task automatic add(input logic r, input logic e, input logic [7:0] q, input logic d,
                     input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
    vec_t p;
    p = '{rst_n: r, en: e, req: q, done: d, gnt: g, idx: i, v: v, to: t};
    plan.push_back(p);
  endtask

  task automatic test_reset();
    int n = 0;
    add(0, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    add(0, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL reset[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  task automatic test_basic();
    int n = 0;
    add(1, 1, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    add(1, 1, 8'h04, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL basic[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer sits at 3 here, so the order is 7, 0, 1, 7.
  task automatic test_wrap();
    int n = 0;
    add(1, 1, 8'h83, 0, 8'h80, 3'd7, 1, 0);
    add(1, 1, 8'h83, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h83, 0, 8'h01, 3'd0, 1, 0);
    add(1, 1, 8'h83, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h83, 0, 8'h02, 3'd1, 1, 0);
    add(1, 1, 8'h83, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h83, 0, 8'h80, 3'd7, 1, 0);
    add(1, 1, 8'h83, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL wrap[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer 0, MAX_HOLD 4: four valid cycles, a timeout pulse, then regrant from ptr 5.
  task automatic test_timeout();
    int n = 0;
    add(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 0, 8'h00, 3'd0, 0, 1);
    add(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(1, 1, 8'h10, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL timeout[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer 5: withdrawal releases without timeout, pointer moves to 6.
  task automatic test_withdraw();
    int n = 0;
    add(1, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    add(1, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h40, 3'd6, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL withdraw[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer 7: abort keeps it at 7, so req=FF next grants 7.
  task automatic test_abort();
    int n = 0;
    add(1, 1, 8'h02, 0, 8'h02, 3'd1, 1, 0);
    add(1, 0, 8'h02, 0, 8'h00, 3'd0, 0, 0);
    add(1, 0, 8'h02, 0, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'h02, 0, 8'h02, 3'd1, 1, 0);
    add(1, 1, 8'h02, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL abort[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer 2: grant 6, reset mid-grant, pointer back to 0.
  task automatic test_reset_mid();
    int n = 0;
    add(1, 1, 8'h40, 0, 8'h40, 3'd6, 1, 0);
    add(0, 1, 8'h40, 0, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL reset_mid[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  // Pointer 1, all requesting: owner keeps the grant until done, then rotation.
  task automatic test_back_to_back();
    int n = 0;
    add(1, 1, 8'hFF, 0, 8'h02, 3'd1, 1, 0);
    add(1, 1, 8'hFF, 0, 8'h02, 3'd1, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h04, 3'd2, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    add(1, 1, 8'hFF, 0, 8'h08, 3'd3, 1, 0);
    add(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    while (plan.size() > 0) begin
      vec_t p; exp_t x; exp_t got;
      p = plan.pop_front();
      rst_n = p.rst_n; bus.en = p.en; bus.req = p.req; bus.done = p.done;
      sb.push_back({p.gnt, p.idx, p.v, p.to});
      @(posedge clk); #1;
      x = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL back_to_back[%0d] got gnt/idx/v/to=%h required=%h", n, got, x);
      end
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
